sys_bus_arbiter: RTL and testbench

- Sits between the icache and dcache bus masters and the single system bus port. Arbitrates ownership with the per-cache busreq/busidle/busgrant handshake.
- Muxes the owner's request signals onto the bus and routes responses back to the owner.
- Forwards snoop-invalidate cycles (resptag == INVAL_TAG) to the dcache regardless of which cache owns the bus.

---
 rtl/sys_bus_pkg.sv | 37 +++
 rtl/sys_bus_arbiter_if.sv | 78 +++++++
 rtl/arb_rr_pick.sv | 33 +++
 rtl/sys_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sys_bus_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_bus_pkg.sv
// -----------------------------------------------------------------------------
// sys_bus_pkg
// Shared types and constants for the system-bus arbiter and the two caches
// that sit behind it.
//   arb_state_t : arbiter ownership phases
//   owner_t     : which cache currently (or last) held the bus
//   INVAL_TAG   : response tag that marks a snoop-invalidate cycle
//   SYSBUS_*    : request-tag field values used when building bus_reqtag
//                 ({direction, kind, 8-bit id} in a 13-bit tag)
// -----------------------------------------------------------------------------
package sys_bus_pkg;

   localparam logic [12:0] INVAL_TAG = 13'h800;

   // Request tag fields shared by icache and dcache
   localparam logic       SYSBUS_READ   = 1'b1;
   localparam logic       SYSBUS_WRITE  = 1'b0;
   localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANTED = 2'd1,
      ARB_BUSY    = 2'd2,
      ARB_TURN    = 2'd3
   } arb_state_t;

   typedef enum logic {
      ICACHE = 1'b0,
      DCACHE = 1'b1
   } owner_t;

   // The master that is not 'o'; used for the round-robin tie break.
   function automatic owner_t other_owner(input owner_t o);
      return (o == ICACHE) ? DCACHE : ICACHE;
   endfunction

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// sys_bus_arbiter_if
// Every signal between the two cache masters, the arbiter and the single
// system-bus port.
//   modport master : the environment side (icache, dcache and system bus)
//   modport slave  : the arbiter
// Per cache (icache_* / dcache_*):
//   busreq, busidle, reqcyc, respack, req, reqtag   cache -> arbiter
//   busgrant, reqack, respcyc, resp, resptag        arbiter -> cache
// System bus:
//   bus_reqcyc, bus_respack, bus_req, bus_reqtag    arbiter -> bus
//   bus_respcyc, bus_reqack, bus_resp, bus_resptag  bus -> arbiter
// -----------------------------------------------------------------------------
interface sys_bus_arbiter_if #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13
);
   // icache
   logic                      icache_busreq;
   logic                      icache_busidle;
   logic                      icache_busgrant;
   logic                      icache_reqcyc;
   logic                      icache_respack;
   logic [BUS_DATA_WIDTH-1:0] icache_req;
   logic [BUS_TAG_WIDTH-1:0]  icache_reqtag;
   logic                      icache_reqack;
   logic                      icache_respcyc;
   logic [BUS_DATA_WIDTH-1:0] icache_resp;
   logic [BUS_TAG_WIDTH-1:0]  icache_resptag;
   // dcache
   logic                      dcache_busreq;
   logic                      dcache_busidle;
   logic                      dcache_busgrant;
   logic                      dcache_reqcyc;
   logic                      dcache_respack;
   logic [BUS_DATA_WIDTH-1:0] dcache_req;
   logic [BUS_TAG_WIDTH-1:0]  dcache_reqtag;
   logic                      dcache_reqack;
   logic                      dcache_respcyc;
   logic [BUS_DATA_WIDTH-1:0] dcache_resp;
   logic [BUS_TAG_WIDTH-1:0]  dcache_resptag;
   // system bus
   logic                      bus_reqcyc;
   logic                      bus_respack;
   logic [BUS_DATA_WIDTH-1:0] bus_req;
   logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
   logic                      bus_respcyc;
   logic                      bus_reqack;
   logic [BUS_DATA_WIDTH-1:0] bus_resp;
   logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

   modport master (
      output icache_busreq, icache_busidle, icache_reqcyc, icache_respack,
             icache_req, icache_reqtag,
      input  icache_busgrant, icache_reqack, icache_respcyc, icache_resp,
             icache_resptag,
      output dcache_busreq, dcache_busidle, dcache_reqcyc, dcache_respack,
             dcache_req, dcache_reqtag,
      input  dcache_busgrant, dcache_reqack, dcache_respcyc, dcache_resp,
             dcache_resptag,
      input  bus_reqcyc, bus_respack, bus_req, bus_reqtag,
      output bus_respcyc, bus_reqack, bus_resp, bus_resptag
   );

   modport slave (
      input  icache_busreq, icache_busidle, icache_reqcyc, icache_respack,
             icache_req, icache_reqtag,
      output icache_busgrant, icache_reqack, icache_respcyc, icache_resp,
             icache_resptag,
      input  dcache_busreq, dcache_busidle, dcache_reqcyc, dcache_respack,
             dcache_req, dcache_reqtag,
      output dcache_busgrant, dcache_reqack, dcache_respcyc, dcache_resp,
             dcache_resptag,
      output bus_reqcyc, bus_respack, bus_req, bus_reqtag,
      input  bus_respcyc, bus_reqack, bus_resp, bus_resptag
   );

endinterface

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
// Combinational two-way round-robin choice.
//   req_i, req_d : icache / dcache ownership requests
//   last_owner   : master granted most recently
//   valid        : at least one request present
//   winner       : chosen master (meaningful only when valid)
// A lone requester always wins; on a tie the master that did not own the bus
// last time wins.
// -----------------------------------------------------------------------------
module arb_rr_pick
   import sys_bus_pkg::*;
(
   input  logic   req_i,
   input  logic   req_d,
   input  owner_t last_owner,
   output logic   valid,
   output owner_t winner
);

   // NOTE: every signal written in an always_comb gets a default on entry so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      valid  = req_i | req_d;
      winner = ICACHE;
      if (req_i && req_d) begin
         winner = other_owner(last_owner);
      end else if (req_d) begin
         winner = DCACHE;
      end
   end

endmodule

// File: rtl/sys_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sys_bus_arbiter
// Arbitrates the single system-bus port between the icache and dcache masters.
//   clk   : clock
//   reset : synchronous, active-low reset
//   port  : sys_bus_arbiter_if.slave, all cache and system-bus signals
// Ownership is handed out through busreq/busgrant and returned when the owner
// reports busidle again (or never starts a transfer within GRANT_TIMEOUT
// cycles). The owner's request lines are muxed onto the bus, reqack/respcyc
// are routed back to the owner only, and resp/resptag are broadcast.
// Snoop-invalidate responses (bus_resptag == INVAL_TAG) always go to the
// dcache, and the arbiter acknowledges them itself when the dcache is not
// driving the bus.
// -----------------------------------------------------------------------------
module sys_bus_arbiter #(
   parameter int                       BUS_DATA_WIDTH = 64,
   parameter int                       BUS_TAG_WIDTH  = 13,
   parameter logic [BUS_TAG_WIDTH-1:0] INVAL_TAG      = sys_bus_pkg::INVAL_TAG,
   parameter int                       GRANT_TIMEOUT  = 16
) (
   input logic              clk,
   input logic              reset,
   sys_bus_arbiter_if.slave port
);

   import sys_bus_pkg::*;

   localparam int                CNT_W     = $clog2(GRANT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(GRANT_TIMEOUT);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   arb_state_t       state_q, state_d;
   owner_t           owner_q, owner_d;
   owner_t           last_owner_q, last_owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             icache_busgrant_q, icache_busgrant_d;
   logic             dcache_busgrant_q, dcache_busgrant_d;

   logic             pick_valid;
   owner_t           pick_owner;
   logic             own_busidle;
   logic [CNT_W-1:0] cnt_inc;

   arb_rr_pick u_pick (
      .req_i      (port.icache_busreq),
      .req_d      (port.dcache_busreq),
      .last_owner (last_owner_q),
      .valid      (pick_valid),
      .winner     (pick_owner)
   );

   assign own_busidle = (owner_q == DCACHE) ? port.dcache_busidle
                                            : port.icache_busidle;
   assign cnt_inc     = cnt_q + CNT_W'(1);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d           = state_q;
      owner_d           = owner_q;
      last_owner_d      = last_owner_q;
      cnt_d             = '0;
      icache_busgrant_d = icache_busgrant_q;
      dcache_busgrant_d = dcache_busgrant_q;

      unique case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d           = ARB_GRANTED;
               owner_d           = pick_owner;
               last_owner_d      = pick_owner;
               icache_busgrant_d = (pick_owner == ICACHE);
               dcache_busgrant_d = (pick_owner == DCACHE);
            end
         end
         ARB_GRANTED: begin
            // The owner holds the grant but has not started a transfer yet;
            // the counter bounds how long it may sit on the bus doing nothing.
            if (!own_busidle) begin
               state_d = ARB_BUSY;
            end else if (cnt_inc == CNT_LIMIT) begin
               state_d           = ARB_TURN;
               icache_busgrant_d = 1'b0;
               dcache_busgrant_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ARB_BUSY: begin
            if (own_busidle) begin
               state_d           = ARB_TURN;
               icache_busgrant_d = 1'b0;
               dcache_busgrant_d = 1'b0;
            end
         end
         ARB_TURN: begin
            // Dead cycle so the next owner never overlaps the previous one.
            state_d = ARB_IDLE;
         end
         default: begin
            state_d           = ARB_IDLE;
            icache_busgrant_d = 1'b0;
            dcache_busgrant_d = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and active-low: it is an ordinary data
      // condition evaluated on the clock edge, not in the sensitivity list.
      if (!reset) begin
         state_q           <= ARB_IDLE;
         owner_q           <= ICACHE;
         last_owner_q      <= ICACHE;
         cnt_q             <= '0;
         icache_busgrant_q <= 1'b0;
         dcache_busgrant_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         owner_q           <= owner_d;
         last_owner_q      <= last_owner_d;
         cnt_q             <= cnt_d;
         icache_busgrant_q <= icache_busgrant_d;
         dcache_busgrant_q <= dcache_busgrant_d;
      end
   end

   assign port.icache_busgrant = icache_busgrant_q;
   assign port.dcache_busgrant = dcache_busgrant_q;

   // ---------------------------------------------------------------------------
   // Request mux and response routing, all from the registered owner
   // ---------------------------------------------------------------------------
   logic                      bus_active;
   logic                      icache_owns;
   logic                      dcache_owns;
   logic                      snoop;
   logic                      own_reqcyc;
   logic                      own_respack;
   logic [BUS_DATA_WIDTH-1:0] own_req;
   logic [BUS_TAG_WIDTH-1:0]  own_reqtag;

   assign bus_active  = (state_q == ARB_GRANTED) || (state_q == ARB_BUSY);
   assign icache_owns = bus_active && (owner_q == ICACHE);
   assign dcache_owns = bus_active && (owner_q == DCACHE);
   assign snoop       = port.bus_respcyc && (port.bus_resptag == INVAL_TAG);

   always_comb begin
      own_reqcyc  = 1'b0;
      own_respack = 1'b0;
      own_req     = '0;
      own_reqtag  = '0;
      if (dcache_owns) begin
         own_reqcyc  = port.dcache_reqcyc;
         own_respack = port.dcache_respack;
         own_req     = port.dcache_req;
         own_reqtag  = port.dcache_reqtag;
      end else if (icache_owns) begin
         own_reqcyc  = port.icache_reqcyc;
         own_respack = port.icache_respack;
         own_req     = port.icache_req;
         own_reqtag  = port.icache_reqtag;
      end
   end

   assign port.bus_reqcyc  = own_reqcyc;
   assign port.bus_req     = own_req;
   assign port.bus_reqtag  = own_reqtag;
   // A snoop must be acknowledged even when the dcache is not driving the bus.
   assign port.bus_respack = own_respack | (snoop & ~dcache_owns);

   assign port.icache_reqack  = port.bus_reqack & icache_owns;
   assign port.dcache_reqack  = port.bus_reqack & dcache_owns;
   assign port.icache_respcyc = port.bus_respcyc & icache_owns & ~snoop;
   assign port.dcache_respcyc = snoop | (port.bus_respcyc & dcache_owns);

   assign port.icache_resp    = port.bus_resp;
   assign port.dcache_resp    = port.bus_resp;
   assign port.icache_resptag = port.bus_resptag;
   assign port.dcache_resptag = port.bus_resptag;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sys_bus_arbiter
// Directed scenarios for grant latency, round robin, muxing, snoop routing,
// timeout and reset, followed by randomized traffic checked against an
// ownership model of the arbiter.
// -----------------------------------------------------------------------------
module tb_sys_bus_arbiter;

   localparam int          DW      = 64;
   localparam int          TW      = 13;
   localparam int          TIMEOUT = 16;
   localparam logic [12:0] INVAL   = 13'h800;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   sys_bus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bif ();

   sys_bus_arbiter #(
      .BUS_DATA_WIDTH (DW),
      .BUS_TAG_WIDTH  (TW),
      .INVAL_TAG      (INVAL),
      .GRANT_TIMEOUT  (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .port  (bif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Advance one clock and move 1 ns past the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic init_inputs();
      bif.icache_busreq  = 1'b0; bif.dcache_busreq  = 1'b0;
      bif.icache_busidle = 1'b1; bif.dcache_busidle = 1'b1;
      bif.icache_reqcyc  = 1'b0; bif.dcache_reqcyc  = 1'b0;
      bif.icache_respack = 1'b0; bif.dcache_respack = 1'b0;
      bif.icache_req     = '0;   bif.dcache_req     = '0;
      bif.icache_reqtag  = '0;   bif.dcache_reqtag  = '0;
      bif.bus_respcyc    = 1'b0; bif.bus_reqack     = 1'b0;
      bif.bus_resp       = '0;   bif.bus_resptag    = '0;
   endtask

   // Owner goes busy for one cycle, goes idle, then the TURN cycle passes.
   task automatic release_owner(input bit dc);
      if (dc) bif.dcache_busidle = 1'b0;
      else    bif.icache_busidle = 1'b0;
      cyc();
      bif.icache_busidle = 1'b1;
      bif.dcache_busidle = 1'b1;
      cyc();
      cyc();
   endtask

   task automatic test_reset();
      init_inputs();
      reset = 1'b0;
      // Non-owner activity during reset must not leak onto the bus.
      bif.icache_reqcyc = 1'b1; bif.icache_req = 64'hFFFF_0000_1234_5678;
      bif.icache_reqtag = 13'h1ABC; bif.icache_respack = 1'b1;
      bif.bus_reqack = 1'b1; bif.bus_respcyc = 1'b1; bif.bus_resptag = 13'h0042;
      cyc();
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b00) begin
         errors++;
         $display("FAIL reset_grants: got %b expected 00",
                  {bif.icache_busgrant, bif.dcache_busgrant});
      end
      checks++;
      if ({bif.bus_reqcyc, bif.bus_respack, bif.bus_req, bif.bus_reqtag} !== 79'd0) begin
         errors++;
         $display("FAIL reset_bus_outputs: got %h expected 0",
                  {bif.bus_reqcyc, bif.bus_respack, bif.bus_req, bif.bus_reqtag});
      end
      checks++;
      if ({bif.icache_reqack, bif.dcache_reqack, bif.icache_respcyc, bif.dcache_respcyc} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_routing: got %b expected 0000",
                  {bif.icache_reqack, bif.dcache_reqack, bif.icache_respcyc, bif.dcache_respcyc});
      end
      init_inputs();
      reset = 1'b1;
   endtask

   task automatic test_single_requester();
      int held;
      bif.dcache_busreq = 1'b1;
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b01) begin
         errors++;
         $display("FAIL single_grant_latency: got %b expected 01",
                  {bif.icache_busgrant, bif.dcache_busgrant});
      end
      // Dropping busreq after the grant must not release the bus.
      bif.dcache_busreq  = 1'b0;
      bif.dcache_busidle = 1'b0;
      held = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if ({bif.icache_busgrant, bif.dcache_busgrant} == 2'b01) held++;
      end
      checks++;
      if (held !== 12) begin
         errors++;
         $display("FAIL single_grant_held: got %0d cycles expected 12", held);
      end
      bif.dcache_busidle = 1'b1;
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b00) begin
         errors++;
         $display("FAIL single_release: got %b expected 00",
                  {bif.icache_busgrant, bif.dcache_busgrant});
      end
      cyc();
   endtask

   task automatic test_tie_round_robin();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      bif.icache_busreq = 1'b1;
      bif.dcache_busreq = 1'b1;
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b01) begin
         errors++;
         $display("FAIL tie1_dcache_first: got %b expected 01",
                  {bif.icache_busgrant, bif.dcache_busgrant});
      end
      bif.dcache_busreq  = 1'b0;
      bif.dcache_busidle = 1'b0;
      cyc();
      bif.dcache_busidle = 1'b1;
      cyc();
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b00) begin
         errors++;
         $display("FAIL tie_turn_dead_cycle: got %b expected 00",
                  {bif.icache_busgrant, bif.dcache_busgrant});
      end
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b10) begin
         errors++;
         $display("FAIL tie_icache_next: got %b expected 10",
                  {bif.icache_busgrant, bif.dcache_busgrant});
      end
      bif.icache_busreq = 1'b0;
      release_owner(1'b0);
      bif.icache_busreq = 1'b1;
      bif.dcache_busreq = 1'b1;
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b01) begin
         errors++;
         $display("FAIL tie2_dcache_again: got %b expected 01",
                  {bif.icache_busgrant, bif.dcache_busgrant});
      end
      bif.icache_busreq = 1'b0;
      bif.dcache_busreq = 1'b0;
      release_owner(1'b1);
   endtask

   task automatic test_mux_route();
      bif.icache_busreq = 1'b1;
      cyc();
      bif.icache_busreq  = 1'b0;
      bif.icache_reqcyc  = 1'b1; bif.icache_req = 64'h1000;
      bif.icache_reqtag  = 13'h0100; bif.icache_respack = 1'b1;
      bif.dcache_reqcyc  = 1'b1; bif.dcache_req = 64'h0BAD;
      bif.dcache_reqtag  = 13'h0055; bif.dcache_respack = 1'b0;
      bif.bus_reqack     = 1'b1; bif.bus_respcyc = 1'b1;
      bif.bus_resp       = 64'h1234_5678; bif.bus_resptag = 13'h0100;
      #1;
      checks++;
      if ({bif.bus_reqcyc, bif.bus_respack, bif.bus_req, bif.bus_reqtag} !==
          {1'b1, 1'b1, 64'h1000, 13'h0100}) begin
         errors++;
         $display("FAIL mux_icache_request: got %h expected %h",
                  {bif.bus_reqcyc, bif.bus_respack, bif.bus_req, bif.bus_reqtag},
                  {1'b1, 1'b1, 64'h1000, 13'h0100});
      end
      checks++;
      if ({bif.icache_reqack, bif.dcache_reqack, bif.icache_respcyc, bif.dcache_respcyc} !== 4'b1010) begin
         errors++;
         $display("FAIL route_to_icache: got %b expected 1010",
                  {bif.icache_reqack, bif.dcache_reqack, bif.icache_respcyc, bif.dcache_respcyc});
      end
      checks++;
      if ({bif.icache_resp, bif.dcache_resp, bif.icache_resptag, bif.dcache_resptag} !==
          {64'h1234_5678, 64'h1234_5678, 13'h0100, 13'h0100}) begin
         errors++;
         $display("FAIL resp_broadcast: got %h expected %h",
                  {bif.icache_resp, bif.dcache_resp, bif.icache_resptag, bif.dcache_resptag},
                  {64'h1234_5678, 64'h1234_5678, 13'h0100, 13'h0100});
      end
      init_inputs();
      release_owner(1'b0);
   endtask

   task automatic test_snoop();
      bif.icache_busreq = 1'b1;
      cyc();
      bif.icache_busreq  = 1'b0;
      bif.icache_busidle = 1'b0;
      cyc();
      bif.bus_respcyc = 1'b1; bif.bus_resptag = INVAL; bif.bus_resp = 64'hDEAD_BEC0;
      #1;
      checks++;
      if ({bif.icache_respcyc, bif.dcache_respcyc, bif.bus_respack} !== 3'b011) begin
         errors++;
         $display("FAIL snoop_icache_owner: got %b expected 011",
                  {bif.icache_respcyc, bif.dcache_respcyc, bif.bus_respack});
      end
      checks++;
      if (bif.dcache_resp !== 64'hDEAD_BEC0) begin
         errors++;
         $display("FAIL snoop_dcache_resp: got %h expected DEADBEC0", bif.dcache_resp);
      end
      init_inputs();
      cyc();
      cyc();
      // With the dcache owning, the snoop ack comes from the dcache only.
      bif.dcache_busreq = 1'b1;
      cyc();
      bif.dcache_busreq = 1'b0;
      bif.bus_respcyc = 1'b1; bif.bus_resptag = INVAL; bif.bus_resp = 64'h55;
      #1;
      checks++;
      if ({bif.icache_respcyc, bif.dcache_respcyc, bif.bus_respack} !== 3'b010) begin
         errors++;
         $display("FAIL snoop_dcache_owner: got %b expected 010",
                  {bif.icache_respcyc, bif.dcache_respcyc, bif.bus_respack});
      end
      init_inputs();
      release_owner(1'b1);
   endtask

   task automatic test_timeout();
      int held;
      bif.dcache_busreq = 1'b1;
      cyc();
      bif.dcache_busreq = 1'b0;
      bif.icache_busreq = 1'b1;
      held = 1;
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         cyc();
         if ({bif.icache_busgrant, bif.dcache_busgrant} == 2'b01) held++;
      end
      checks++;
      if (held !== TIMEOUT) begin
         errors++;
         $display("FAIL timeout_grant_held: got %0d cycles expected %0d", held, TIMEOUT);
      end
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b00) begin
         errors++;
         $display("FAIL timeout_drop: got %b expected 00",
                  {bif.icache_busgrant, bif.dcache_busgrant});
      end
      cyc();
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b10) begin
         errors++;
         $display("FAIL timeout_pending_grant: got %b expected 10",
                  {bif.icache_busgrant, bif.dcache_busgrant});
      end
      bif.icache_busreq = 1'b0;
      release_owner(1'b0);
   endtask

   task automatic test_reset_mid_transfer();
      bif.dcache_busreq = 1'b1;
      cyc();
      bif.dcache_busreq  = 1'b0;
      bif.dcache_busidle = 1'b0;
      bif.dcache_reqcyc  = 1'b1;
      cyc();
      checks++;
      if ({bif.dcache_busgrant, bif.bus_reqcyc} !== 2'b11) begin
         errors++;
         $display("FAIL busy_before_reset: got %b expected 11",
                  {bif.dcache_busgrant, bif.bus_reqcyc});
      end
      reset = 1'b0;
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant, bif.bus_reqcyc} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_transfer: got %b expected 000",
                  {bif.icache_busgrant, bif.dcache_busgrant, bif.bus_reqcyc});
      end
      reset = 1'b1;
      init_inputs();
      bif.icache_busreq = 1'b1;
      cyc();
      checks++;
      if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b10) begin
         errors++;
         $display("FAIL post_reset_grant: got %b expected 10",
                  {bif.icache_busgrant, bif.dcache_busgrant});
      end
      bif.icache_busreq = 1'b0;
      release_owner(1'b0);
   endtask

   // Randomized traffic. The model tracks who holds the bus (0 none, 1 icache,
   // 2 dcache), whether the holder has started a transfer, how long it has
   // held the bus without starting, and whether the hand-over gap is pending.
   task automatic test_random();
      int          owner, last, idle_cycles;
      bit          started, gap;
      bit          snoop, owner_idle;
      logic        e_cyc, e_ack;
      logic [63:0] e_req;
      logic [12:0] e_tag;
      logic [3:0]  e_route;

      reset = 1'b0;
      init_inputs();
      cyc();
      reset = 1'b1;
      owner = 0; last = 1; idle_cycles = 0; started = 0; gap = 0;

      for (int n = 0; n < 2000; n++) begin
         reset               = ($urandom_range(0, 299) != 0);
         bif.icache_busreq   = ($urandom_range(0, 2) == 0);
         bif.dcache_busreq   = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) bif.icache_busidle = ~bif.icache_busidle;
         if ($urandom_range(0, 7) == 0) bif.dcache_busidle = ~bif.dcache_busidle;
         bif.icache_reqcyc   = $urandom_range(0, 1);
         bif.dcache_reqcyc   = $urandom_range(0, 1);
         bif.icache_respack  = $urandom_range(0, 1);
         bif.dcache_respack  = $urandom_range(0, 1);
         bif.icache_req      = {$urandom, $urandom};
         bif.dcache_req      = {$urandom, $urandom};
         bif.icache_reqtag   = 13'($urandom);
         bif.dcache_reqtag   = 13'($urandom);
         bif.bus_reqack      = $urandom_range(0, 1);
         bif.bus_respcyc     = $urandom_range(0, 1);
         bif.bus_resp        = {$urandom, $urandom};
         bif.bus_resptag     = ($urandom_range(0, 3) == 0) ? INVAL : 13'($urandom);
         #1;

         snoop = bif.bus_respcyc && (bif.bus_resptag == INVAL);
         e_cyc = 1'b0; e_ack = 1'b0; e_req = '0; e_tag = '0;
         if (owner == 1) begin
            e_cyc = bif.icache_reqcyc; e_ack = bif.icache_respack;
            e_req = bif.icache_req;    e_tag = bif.icache_reqtag;
         end else if (owner == 2) begin
            e_cyc = bif.dcache_reqcyc; e_ack = bif.dcache_respack;
            e_req = bif.dcache_req;    e_tag = bif.dcache_reqtag;
         end
         e_ack   = e_ack | (snoop && owner != 2);
         e_route = {bif.bus_reqack && owner == 1, bif.bus_reqack && owner == 2,
                    bif.bus_respcyc && owner == 1 && !snoop,
                    snoop || (bif.bus_respcyc && owner == 2)};

         checks++;
         if ({bif.icache_busgrant, bif.dcache_busgrant} !== {owner == 1, owner == 2}) begin
            errors++;
            $display("FAIL rand_grant n=%0d: got %b expected %b", n,
                     {bif.icache_busgrant, bif.dcache_busgrant}, {owner == 1, owner == 2});
         end
         checks++;
         if ({bif.bus_reqcyc, bif.bus_respack, bif.bus_req, bif.bus_reqtag} !==
             {e_cyc, e_ack, e_req, e_tag}) begin
            errors++;
            $display("FAIL rand_bus_mux n=%0d: got %h expected %h", n,
                     {bif.bus_reqcyc, bif.bus_respack, bif.bus_req, bif.bus_reqtag},
                     {e_cyc, e_ack, e_req, e_tag});
         end
         checks++;
         if ({bif.icache_reqack, bif.dcache_reqack, bif.icache_respcyc, bif.dcache_respcyc} !== e_route) begin
            errors++;
            $display("FAIL rand_route n=%0d: got %b expected %b", n,
                     {bif.icache_reqack, bif.dcache_reqack, bif.icache_respcyc, bif.dcache_respcyc},
                     e_route);
         end
         checks++;
         if ({bif.icache_resp, bif.dcache_resp, bif.icache_resptag, bif.dcache_resptag} !==
             {bif.bus_resp, bif.bus_resp, bif.bus_resptag, bif.bus_resptag}) begin
            errors++;
            $display("FAIL rand_broadcast n=%0d: got %h expected %h", n,
                     {bif.icache_resp, bif.dcache_resp, bif.icache_resptag, bif.dcache_resptag},
                     {bif.bus_resp, bif.bus_resp, bif.bus_resptag, bif.bus_resptag});
         end

         @(posedge clk);
         if (!reset) begin
            owner = 0; last = 1; idle_cycles = 0; started = 0; gap = 0;
         end else if (owner != 0) begin
            owner_idle = (owner == 1) ? bif.icache_busidle : bif.dcache_busidle;
            if (started) begin
               if (owner_idle) begin owner = 0; gap = 1; end
            end else if (!owner_idle) begin
               started = 1;
            end else begin
               idle_cycles++;
               if (idle_cycles >= TIMEOUT) begin owner = 0; gap = 1; end
            end
         end else if (gap) begin
            gap = 0;
         end else if (bif.icache_busreq || bif.dcache_busreq) begin
            if (bif.icache_busreq && bif.dcache_busreq) owner = 3 - last;
            else owner = bif.icache_busreq ? 1 : 2;
            last = owner; started = 0; idle_cycles = 0;
         end
         #1;
      end
      reset = 1'b1;
      init_inputs();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      init_inputs();
      test_reset();
      test_single_requester();
      test_tie_round_robin();
      test_mux_route();
      test_snoop();
      test_timeout();
      test_reset_mid_transfer();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
